// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM states, size/resp encodings and the strobe base mask
package mem_access_pkg;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [3:0] strb_base(input logic [1:0] size);
    return size == SZ_B ? 4'b0001 : size == SZ_H ? 4'b0011 : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational store lane shift/strobes, load extract/extend, misalignment flag
// ports: ofs/size/sgn/wdata/rdata in; wdata_sh/wstrb/rdata_ext/misaligned out
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  ofs,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_sh,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);
  logic [31:0] rsh;
  always_comb begin
    wstrb = strb_base(size) << ofs;
    wdata_sh = wdata << {ofs, 3'b000};
    rsh = rdata >> {ofs, 3'b000};
    rdata_ext = size == SZ_B ? {{24{sgn & rsh[7]}}, rsh[7:0]} :
                size == SZ_H ? {{16{sgn & rsh[15]}}, rsh[15:0]} : rsh;
    misaligned = (size == SZ_H && ofs[0]) || (size[1] && ofs != 2'b00);
  end
endmodule

// File: rtl/mem_access_master.sv
// mem_access_master: load/store request to single AXI4-Lite transaction bridge
// ports: clk/rst, req_* handshake in, resp_valid/resp_data (+resp_fault with MEM_ACCESS_FAULT_EN) out, m_* AXI4-Lite master
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
`ifdef MEM_ACCESS_FAULT_EN
  output logic        resp_fault,
`endif
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  output logic [2:0]  m_arprot,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  output logic [2:0]  m_awprot,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);
  state_t st, nxt;
  logic [31:0] addr_q, wdata_q, rdata_ext;
  logic [1:0] size_q, al_ofs, al_size;
  logic sgn_q, aw_done, w_done, aw_ok, w_ok, misaligned, skip;
  // the aligner looks at the live request while idle so misalignment is known at accept
  assign al_ofs = st == IDLE ? req_addr[1:0] : addr_q[1:0];
  assign al_size = st == IDLE ? req_size : size_q;
  mem_lane_align u_align (
    .ofs(al_ofs),
    .size(al_size),
    .sgn(sgn_q),
    .wdata(wdata_q),
    .rdata(m_rdata),
    .wdata_sh(m_wdata),
    .wstrb(m_wstrb),
    .rdata_ext(rdata_ext),
    .misaligned(misaligned)
  );
`ifdef MEM_ACCESS_FAULT_EN
  assign skip = misaligned;
`else
  logic resp_unused;
  assign skip = 1'b0;
  assign resp_unused = ^{m_rresp, m_bresp, misaligned};
`endif
  assign req_ready = st == IDLE && !rst;
  assign m_arvalid = st == RADDR;
  assign m_rready = st == RDATA;
  assign m_awvalid = st == WREQ && !aw_done;
  assign m_wvalid = st == WREQ && !w_done;
  assign m_bready = st == WRESP;
  assign resp_valid = st == DONE;
  assign m_araddr = {addr_q[31:2], 2'b00};
  assign m_awaddr = {addr_q[31:2], 2'b00};
  assign m_arprot = PROT;
  assign m_awprot = PROT;
  always_comb begin
    nxt = st;
    aw_ok = aw_done | m_awready;
    w_ok = w_done | m_wready;
    unique case (st)
      IDLE: nxt = !req_valid ? IDLE : skip ? DONE : req_we ? WREQ : RADDR;
      RADDR: nxt = m_arready ? RDATA : RADDR;
      RDATA: nxt = m_rvalid ? DONE : RDATA;
      WREQ: nxt = aw_ok && w_ok ? WRESP : WREQ;
      WRESP: nxt = m_bvalid ? DONE : WRESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= SZ_B;
      sgn_q <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      resp_data <= '0;
`ifdef MEM_ACCESS_FAULT_EN
      resp_fault <= 1'b0;
`endif
    end else begin
      st <= nxt;
      if (st == IDLE && req_valid) begin
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        size_q <= req_size;
        sgn_q <= req_signed;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        resp_data <= '0;
`ifdef MEM_ACCESS_FAULT_EN
        resp_fault <= skip;
`endif
      end
      if (st == RDATA && m_rvalid) begin
        resp_data <= rdata_ext;
`ifdef MEM_ACCESS_FAULT_EN
        resp_fault <= m_rresp != RESP_OKAY;
`endif
      end
      if (st == WREQ) begin
        aw_done <= aw_ok;
        w_done <= w_ok;
      end
`ifdef MEM_ACCESS_FAULT_EN
      if (st == WRESP && m_bvalid) resp_fault <= m_bresp != RESP_OKAY;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: directed + randomized checks against a byte-level memory model
module tb_mem_access_master;
  import mem_access_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_size = '0;
  logic resp_valid, resp_fault_w;
  logic [31:0] resp_data;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [2:0] m_arprot, m_awprot;
  logic [1:0] m_rresp, m_bresp;
  logic [3:0] m_wstrb;
  mem_access_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef MEM_ACCESS_FAULT_EN
    .resp_fault(resp_fault_w),
`endif
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arprot(m_arprot), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awprot(m_awprot), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );
`ifndef MEM_ACCESS_FAULT_EN
  assign resp_fault_w = 1'b0;
`endif
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0, resp_cnt = 0, arv_cnt = 0, awv_cnt = 0, wv_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (resp_valid) resp_cnt++;
    if (m_arvalid) arv_cnt++;
    if (m_awvalid) awv_cnt++;
    if (m_wvalid) wv_cnt++;
  end
  // slave model: per-channel ready/valid delays, word memory written through strobes
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
  bit r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  logic [1:0] rresp_v = 2'b00, bresp_v = 2'b00;
  logic [31:0] ar_a = '0, aw_a = '0, w_d = '0;
  logic [3:0] w_s = '0;
  logic [31:0] smem [logic [29:0]];
  logic [7:0] mb [32];
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return smem.exists(a[31:2]) ? smem[a[31:2]] : 32'h0;
  endfunction
  initial begin
    {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
    m_rdata = '0;
    m_rresp = '0;
    m_bresp = '0;
    forever begin
      @(negedge clk);
      {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
      if (rst) begin
        {r_pend, aw_got, w_got, b_pend} = '0;
        {ar_c, r_c, aw_c, w_c, b_c} = '0;
      end else begin
        if (r_pend) begin
          if (r_c >= r_dly) begin
            m_rvalid = 1'b1; m_rdata = rd_word(ar_a); m_rresp = rresp_v; r_pend = 0;
          end else r_c++;
        end
        if (m_arvalid) begin
          if (ar_c >= ar_dly) begin
            m_arready = 1'b1; ar_a = m_araddr; r_pend = 1; r_c = 0; ar_c = 0;
          end else ar_c++;
        end
        if (b_pend) begin
          if (b_c >= b_dly) begin
            m_bvalid = 1'b1; m_bresp = bresp_v; b_pend = 0;
          end else b_c++;
        end
        if (m_awvalid && !aw_got) begin
          if (aw_c >= aw_dly) begin
            m_awready = 1'b1; aw_a = m_awaddr; aw_got = 1; aw_c = 0;
          end else aw_c++;
        end
        if (m_wvalid && !w_got) begin
          if (w_c >= w_dly) begin
            m_wready = 1'b1; w_d = m_wdata; w_s = m_wstrb; w_got = 1; w_c = 0;
          end else w_c++;
        end
        if (aw_got && w_got) begin
          logic [31:0] word;
          word = rd_word(aw_a);
          for (int b = 0; b < 4; b++) if (w_s[b]) word[8*b +: 8] = w_d[8*b +: 8];
          smem[aw_a[31:2]] = word;
          aw_got = 0; w_got = 0; b_pend = 1; b_c = 0;
        end
      end
    end
  end
  // reference model over bytes 0..31: a request touches bytes off..off+n-1 that fall inside the word
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] model_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int n, base, off;
    logic [31:0] v;
    n = nbytes(sz);
    base = 4 * int'(a[4:2]);
    off = int'(a[1:0]);
    v = '0;
    for (int i = 0; i < n; i++) if (off + i < 4) v[8*i +: 8] = mb[base + off + i];
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction
  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n, base, off;
    n = nbytes(sz);
    base = 4 * int'(a[4:2]);
    off = int'(a[1:0]);
    for (int i = 0; i < n; i++) if (off + i < 4) mb[base + off + i] = wd[8*i +: 8];
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic sg,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat, output logic flt);
    int t, k;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    chk("req_ready_seen", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wd;
    k = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 100) begin @(negedge clk); t++; end
    chk("resp_seen", resp_valid, 1);
    lat = resp_valid ? cyc - k : -1;
    rd = resp_data;
    flt = resp_fault_w;
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
    chk("next_ready", req_ready, 1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] rd;
    logic flt;
    int lat, r0, aw0, w0, t;
    for (int w = 0; w < 8; w++) begin
      logic [31:0] v;
      v = $urandom;
      smem[30'(w)] = v;
      {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]} = v;
    end
    smem[30'h400] = 32'h80FF_FF00;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_valids", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid}, 0);
    chk("rst_regs", m_araddr | m_awaddr | m_wdata | resp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    do_req(1'b0, 32'h1003, 2'd0, 1'b1, 32'h0, rd, lat, flt);
    chk("ldb_araddr", ar_a, 32'h1000);
    chk("ldb_data", rd, 32'hFFFF_FF80);
    chk("ldb_lat", lat, 3);
    do_req(1'b1, 32'h2002, 2'd1, 1'b0, 32'h0000_BEEF, rd, lat, flt);
    chk("sth_awaddr", aw_a, 32'h2000);
    chk("sth_wdata", w_d, 32'hBEEF_0000);
    chk("sth_wstrb", w_s, 4'b1100);
    chk("sth_data", rd, 0);
    chk("sth_lat", lat, 3);
    aw_dly = 3;
    r0 = resp_cnt; aw0 = awv_cnt; w0 = wv_cnt;
    do_req(1'b1, 32'h3000, 2'd2, 1'b0, 32'hCAFE_F00D, rd, lat, flt);
    chk("dly_awvalid_cycles", awv_cnt - aw0, 4);
    chk("dly_wvalid_cycles", wv_cnt - w0, 1);
    chk("dly_resp_count", resp_cnt - r0, 1);
    chk("dly_mem", smem[30'hC00], 32'hCAFE_F00D);
    aw_dly = 0;
    for (int i = 0; i < 30; i++) begin
      logic we, sg, mis;
      logic [1:0] sz;
      logic [31:0] a, wd, exp;
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      wd = $urandom;
      ar_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 2);
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2); b_dly = $urandom_range(0, 2);
      mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
      exp = we ? 32'h0 : model_load(a, sz, sg);
`ifdef MEM_ACCESS_FAULT_EN
      if (mis) exp = 32'h0;
      else if (we) model_store(a, sz, wd);
`else
      if (we) model_store(a, sz, wd);
`endif
      do_req(we, a, sz, sg, wd, rd, lat, flt);
      chk("rnd_data", rd, exp);
      if (we) chk("rnd_mem", smem[a[31:2]], model_word(int'(a[4:2])));
`ifdef MEM_ACCESS_FAULT_EN
      chk("rnd_fault", flt, mis);
      if (mis) chk("rnd_mis_lat", lat, 1);
`endif
    end
    {ar_dly, r_dly, aw_dly, w_dly, b_dly} = '0;
    r_dly = 5;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd2; req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!m_rready && t < 20) begin @(negedge clk); t++; end
    chk("rst_reach_rdata", m_rready, 1);
    r0 = resp_cnt;
    #1 rst = 1'b1;
    #1 chk("rst_async_drop", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid, req_ready}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r_dly = 0;
    repeat (8) @(negedge clk);
    chk("rst_no_resp", resp_cnt - r0, 0);
    do_req(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, rd, lat, flt);
    chk("post_rst_data", rd, model_word(0));
    chk("post_rst_lat", lat, 3);
`ifdef MEM_ACCESS_FAULT_EN
    r0 = arv_cnt;
    do_req(1'b0, 32'h1, 2'd2, 1'b0, 32'h0, rd, lat, flt);
    chk("mis_no_ar", arv_cnt - r0, 0);
    chk("mis_fault", flt, 1);
    chk("mis_lat", lat, 1);
    chk("mis_data", rd, 0);
    bresp_v = RESP_SLVERR;
    do_req(1'b1, 32'h3000, 2'd2, 1'b0, 32'h1234_5678, rd, lat, flt);
    chk("bresp_fault", flt, 1);
    bresp_v = RESP_OKAY;
    rresp_v = RESP_SLVERR;
    do_req(1'b0, 32'h3000, 2'd2, 1'b0, 32'h0, rd, lat, flt);
    chk("rresp_fault", flt, 1);
    rresp_v = RESP_OKAY;
    do_req(1'b0, 32'h3000, 2'd2, 1'b0, 32'h0, rd, lat, flt);
    chk("okay_no_fault", flt, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_master.md
# mem_access_master

Bridge between the core's load/store unit and the data-cache slave AXI4-Lite port. Accepts one load or store request at a time, handles byte/halfword/word lane alignment and write strobes, drives a single AXI4-Lite transaction into the cache, and returns the load data, extended and right-aligned, as a one-cycle response pulse. Sits directly upstream of the cache's s_* port group.

## Interface
- PROT, default 3'b000: value driven on m_arprot / m_awprot.

Ports (* = feature-dependent, see Configuration):
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- req_signed  in  1  load sign-extend (1) or zero-extend (0).
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_data  out  32  load result (0 for stores).
- resp_fault  out  1  * error on completion.
- m_araddr/m_arvalid/m_arprot out 32/1/3; m_arready in 1.
- m_rdata in 32, m_rresp in 2, m_rvalid in 1; m_rready out 1.
- m_awaddr/m_awvalid/m_awprot out 32/1/3; m_awready in 1.
- m_wdata out 32, m_wstrb out 4, m_wvalid out 1; m_wready in 1.
- m_bresp in 2, m_bvalid in 1; m_bready out 1.

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE. Reset state IDLE.
- IDLE: req_ready=1. On req_valid, latch all req_* fields, then go to RADDR (load) or WREQ (store).
- RADDR: m_arvalid=1, m_araddr={addr[31:2],2'b00}. Hold until m_arready, then go to RDATA.
- RDATA: m_rready=1. On m_rvalid, capture the extracted data and m_rresp, then go to DONE.
- Load extract: shift m_rdata right by 8*addr[1:0], mask to size, then sign- or zero-extend per req_signed.
- WREQ: m_awvalid and m_wvalid assert together in the first WREQ cycle.
  - Each deasserts independently after its own handshake; aw_done and w_done flags track this.
  - When both handshakes are done, go to WRESP.
- Store data and strobes: m_wdata = wdata << 8*addr[1:0]; m_wstrb = {1,3,F}[size] << addr[1:0], truncated to 4 bits. m_awaddr word-aligned.
- WRESP: m_bready=1. On m_bvalid, capture m_bresp, then go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then go to IDLE.
- All AXI valid outputs are registered. No new request is accepted before DONE has passed.

## Timing
- Reset values: every m_*valid, m_rready, m_bready, resp_valid, resp_fault = 0; resp_data = 0; address/data registers = 0. req_ready = 0 while rst is high.
- Minimum latency, with the slave ready every cycle (accept at edge 0):
  - load: arvalid in cycle 1, rvalid seen in cycle 2, resp_valid in cycle 3;
  - store: aw/w in cycle 1, bvalid in cycle 2, resp_valid in cycle 3.
- m_arvalid, m_awvalid and m_wvalid never drop before their handshake; address, data and strobe stay stable while valid.
- AW and W handshakes in the same cycle: both done, WRESP next cycle. Handshakes in different cycles: both orders are legal.
- Back-to-back requests: the next req_ready is high one cycle after resp_valid.
- rst mid-transaction: the transaction is abandoned and all valids drop immediately; no response is produced. The cache is reset together with this block.

## Configuration
- MEM_ACCESS_FAULT_EN defined:
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) skips the bus and goes IDLE→DONE with resp_fault=1 and resp_data=0.
  - Any m_rresp or m_bresp other than 2'b00 gives resp_fault=1.
- MEM_ACCESS_FAULT_EN undefined:
  - The resp_fault port is absent.
  - Misaligned accesses are issued with truncated strobes and lanes; AXI resp codes are ignored.

## Structure
- Shared package mem_access_pkg: state enum, size encodings (SZ_B/SZ_H/SZ_W), AXI resp constants (RESP_OKAY, RESP_SLVERR), the strobe base-mask function.
- One sub-module: mem_lane_align, purely combinational. It performs the store shift, strobe generation, load extract/extend and the misalignment flag.

## Test plan
- Load byte, addr 0x1003, signed, rdata 0x80FF_FF00, slave always ready → araddr 0x1000; resp_data 0xFFFF_FF80 at cycle 3.
- Store half, addr 0x2002, wdata 0x0000_BEEF → awaddr 0x2000, wdata 0xBEEF_0000, wstrb 4'b1100; resp_valid with resp_data 0.
- Store with awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles; a single resp_valid.
- With MEM_ACCESS_FAULT_EN: word load at 0x0001 → no arvalid; resp_fault=1 one cycle after accept. bresp=2'b10 on a store → resp_fault=1.
- Assert rst while in RDATA → m_rready and all valids go to 0 asynchronously; no resp_valid; after release, a load at 0x0 completes normally.
